memory_stage: RTL and testbench

Load/store pipeline stage directly downstream of the execute stage. It latches the executed instruction, its ALU result (the effective address for loads and stores) and `rs2`, and issues one data-memory transaction per load or store over a request/grant/rvalid bus. It aligns and sign-extends load data and presents a single write-back value to the next stage. Non-memory instructions pass through with one cycle of latency.

---
 rtl/memory_stage.sv | 169 ++++++++++++++++
 tb/tb_memory_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - load/store pipeline stage with aligned data-memory bus access
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] result_i,
    input  logic [31:0] rs2_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] data_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_next;

    logic [31:0] instr_q, addr_q, rs2_q, data_q;
    logic        mis_q, err_q;
    logic [15:0] cnt;

    // decode of the incoming instruction; only meaningful on the accept edge
    logic [2:0] f3_in;
    logic       is_load_in, is_store_in, legal_in, aligned_in, pass_in, fault_in;

    always_comb begin
        f3_in       = instr_i[14:12];
        is_load_in  = (instr_i[6:0] == OP_LOAD);
        is_store_in = (instr_i[6:0] == OP_STORE);
        legal_in    = 1'b0;
        if (is_load_in)
            legal_in = f3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (is_store_in)
            legal_in = f3_in inside {3'b000, 3'b001, 3'b010};
        case (f3_in[1:0])
            2'b01:   aligned_in = !result_i[0];
            2'b10:   aligned_in = (result_i[1:0] == 2'b00);
            default: aligned_in = 1'b1;
        endcase
        pass_in  = !is_load_in && !is_store_in;
        fault_in = !pass_in && !(legal_in && aligned_in);
    end

    logic        is_store_q, cnt_hit;
    logic [2:0]  f3_q;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic [31:0] wdata, lane_data, load_val;

    assign is_store_q = (instr_q[6:0] == OP_STORE);
    assign f3_q       = instr_q[14:12];
    assign lane       = addr_q[1:0];
    assign cnt_hit    = (cnt == CNT_LIMIT);

    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{rs2_q[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << lane;
                wdata = {2{rs2_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = rs2_q;
            end
        endcase
        lane_data = mem_rdata_i >> {lane, 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{lane_data[7]}}, lane_data[7:0]};
            3'b001:  load_val = {{16{lane_data[15]}}, lane_data[15:0]};
            3'b100:  load_val = {24'h0, lane_data[7:0]};
            3'b101:  load_val = {16'h0, lane_data[15:0]};
            default: load_val = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_next;
    end

    // a response in the timeout cycle is checked first, so it wins over the error
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (valid_i) state_next = (pass_in || fault_in) ? DONE : REQ;
            REQ: begin
                if (mem_gnt_i)    state_next = is_store_q ? DONE : WAIT;
                else if (cnt_hit) state_next = DONE;
            end
            WAIT: if (mem_rvalid_i || cnt_hit) state_next = DONE;
            DONE: if (ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o      = (state == IDLE);
        valid_o      = (state == DONE);
        mem_req_o    = (state == REQ);
        misaligned_o = (state == DONE) && mis_q;
        bus_err_o    = (state == DONE) && err_q;
        mem_we_o     = 1'b0;
        mem_addr_o   = 32'h0;
        mem_be_o     = 4'h0;
        mem_wdata_o  = 32'h0;
        if (state == REQ) begin
            mem_we_o    = is_store_q;
            mem_addr_o  = {addr_q[31:2], 2'b00};
            mem_be_o    = be;
            mem_wdata_o = is_store_q ? wdata : 32'h0;
        end
    end

    assign instr_o = instr_q;
    assign data_o  = data_q;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            instr_q <= 32'h0;
            addr_q  <= 32'h0;
            rs2_q   <= 32'h0;
            data_q  <= 32'h0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= 16'h0;
        end else begin
            case (state)
                IDLE: if (valid_i) begin
                    instr_q <= instr_i;
                    addr_q  <= result_i;
                    rs2_q   <= rs2_i;
                    data_q  <= pass_in ? result_i : 32'h0;
                    mis_q   <= fault_in;
                    err_q   <= 1'b0;
                end
                REQ: if (!mem_gnt_i && cnt_hit) err_q <= 1'b1;
                WAIT: begin
                    if (mem_rvalid_i) data_q <= load_val;
                    else if (cnt_hit) err_q <= 1'b1;
                end
                default: ;
            endcase
            if (state_next != state && (state_next == REQ || state_next == WAIT))
                cnt <= 16'h0;
            else if (state == REQ || state == WAIT)
                cnt <= cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage
module tb_memory_stage;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rstn_i, valid_i, ready_o, valid_o, ready_i;
    logic [31:0] instr_i, result_i, rs2_i, instr_o, data_o;
    logic        misaligned_o, bus_err_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;

    memory_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .result_i(result_i), .rs2_i(rs2_i),
        .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .data_o(data_o),
        .misaligned_o(misaligned_o), .bus_err_o(bus_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit          access;
        bit          we;
        int          lat;
        int          req_last;
        logic [31:0] instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        logic [3:0]  be;
        bit          mis;
        bit          err;
    } exp_t;

    int   n_vec = 0, n_err = 0;
    int   cyc = -1, rdy_dly = 0;
    bit   chk_en = 0;
    exp_t cur;
    logic [31:0] cap_data = 0, cap_wdata = 0, cap_addr = 0;
    logic [3:0]  cap_be = 0;
    logic        cap_mis = 0, cap_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {12'h0A5, 5'd2, f3, 5'd7, op};
    endfunction

    // expected outcome of one transaction: latency, bus fields and write-back
    function automatic exp_t model(input logic [31:0] ins, a, r2, rd, input int g, r);
        exp_t        e;
        logic [2:0]  f3;
        logic [31:0] v;
        int          nb, ln;
        bit          load, store, legal;
        e     = '0;
        e.instr = ins;
        f3    = ins[14:12];
        ln    = int'(a[1:0]);
        load  = (ins[6:0] == 7'b0000011);
        store = (ins[6:0] == 7'b0100011);
        nb    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (!load && !store) begin
            e.data = a;
            e.lat  = 1;
            return e;
        end
        legal = load ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        if (!legal || (ln % nb) != 0) begin
            e.mis = 1;
            e.lat = 1;
            return e;
        end
        e.access = 1;
        e.we     = store;
        e.addr   = a & ~32'h3;
        e.be     = 4'((1 << nb) - 1) << ln;
        if (store)
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = r2[8*(i % nb) +: 8];
        if (g >= T) begin
            e.req_last = T;
            e.lat      = T + 1;
            e.err      = 1;
            return e;
        end
        e.req_last = g + 1;
        if (store) begin
            e.lat = g + 2;
            return e;
        end
        if (r >= T) begin
            e.lat = g + 2 + T;
            e.err = 1;
            return e;
        end
        e.lat = g + 3 + r;
        v = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(ln + i) +: 8];
        if (nb < 4 && !f3[2] && v[8*nb-1])
            for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
        e.data = v;
        return e;
    endfunction

    always @(negedge clk) begin
        logic ev, er;
        if (chk_en) begin
            if (cyc < 1) begin
                check("ready_o idle", 32'(ready_o), 32'd1);
                check("valid_o idle", 32'(valid_o), 32'd0);
                check("mem_req_o idle", 32'(mem_req_o), 32'd0);
            end else begin
                ev = (cyc >= cur.lat) && (cyc <= cur.lat + rdy_dly);
                er = cur.access && (cyc <= cur.req_last);
                check("ready_o busy", 32'(ready_o), 32'd0);
                check("valid_o", 32'(valid_o), 32'(ev));
                check("mem_req_o", 32'(mem_req_o), 32'(er));
                if (er) begin
                    check("mem_addr_o", mem_addr_o, cur.addr);
                    check("mem_be_o", 32'(mem_be_o), 32'(cur.be));
                    check("mem_wdata_o", mem_wdata_o, cur.wdata);
                    check("mem_we_o", 32'(mem_we_o), 32'(cur.we));
                    cap_addr  = mem_addr_o;
                    cap_be    = mem_be_o;
                    cap_wdata = mem_wdata_o;
                end
                if (ev) begin
                    check("data_o", data_o, cur.data);
                    check("instr_o", instr_o, cur.instr);
                    check("misaligned_o", 32'(misaligned_o), 32'(cur.mis));
                    check("bus_err_o", 32'(bus_err_o), 32'(cur.err));
                    cap_data = data_o;
                    cap_mis  = misaligned_o;
                    cap_err  = bus_err_o;
                end
            end
        end
    end

    // called #1 after a rising edge; g = REQ cycles without grant, r = WAIT cycles without rvalid
    task automatic run_op(input logic [31:0] ins, a, r2, rd, input int g, r, rdy);
        cur          = model(ins, a, r2, rd, g, r);
        rdy_dly      = rdy;
        cyc          = 0;
        valid_i      = 1'b1;
        instr_i      = ins;
        result_i     = a;
        rs2_i        = r2;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEADBEEF;
        ready_i      = 1'b0;
        @(posedge clk); #1;
        valid_i  = 1'b0;
        instr_i  = $urandom;
        result_i = $urandom;
        rs2_i    = $urandom;
        for (int k = 1; k <= cur.lat + rdy; k++) begin
            cyc          = k;
            mem_gnt_i    = (k == g + 1);
            mem_rvalid_i = (k == g + 1) || (k == g + 2 + r);
            mem_rdata_i  = (k == g + 2 + r) ? rd : 32'hDEADBEEF;
            ready_i      = (k >= cur.lat + rdy);
            @(posedge clk); #1;
        end
        cyc          = -1;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        ready_i      = 1'b0;
    endtask

    localparam logic [6:0] OPL = 7'b0000011, OPS = 7'b0100011, OPA = 7'b0110011;

    initial begin
        rstn_i = 1'b0; valid_i = 1'b0; instr_i = 0; result_i = 0; rs2_i = 0;
        ready_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 0;
        #12;
        check("rst ready_o", 32'(ready_o), 32'd1);
        check("rst valid_o", 32'(valid_o), 32'd0);
        check("rst mem_req_o", 32'(mem_req_o), 32'd0);
        check("rst mem_we_o", 32'(mem_we_o), 32'd0);
        check("rst mem_be_o", 32'(mem_be_o), 32'd0);
        check("rst mem_addr_o", mem_addr_o, 32'd0);
        check("rst mem_wdata_o", mem_wdata_o, 32'd0);
        check("rst data_o", data_o, 32'd0);
        check("rst instr_o", instr_o, 32'd0);
        check("rst misaligned_o", 32'(misaligned_o), 32'd0);
        check("rst bus_err_o", 32'(bus_err_o), 32'd0);
        @(posedge clk); #1;
        rstn_i = 1'b1;
        chk_en = 1;
        @(posedge clk); #1;

        run_op(mk(OPA, 3'd0), 32'h1234, 32'h0, 32'h0, 0, 0, 0);
        check("pin add data", cap_data, 32'h0000_1234);
        run_op(mk(OPL, 3'd0), 32'h1003, 32'h0, 32'h80FF_FF7F, 0, 0, 0);
        check("pin lb data", cap_data, 32'hFFFF_FF80);
        check("pin lb be", 32'(cap_be), 32'h8);
        check("pin lb addr", cap_addr, 32'h1000);
        run_op(mk(OPL, 3'd5), 32'h2002, 32'h0, 32'h8001_0000, 0, 0, 0);
        check("pin lhu data", cap_data, 32'h0000_8001);
        run_op(mk(OPS, 3'd0), 32'h11, 32'hAB, 32'h0, 2, 0, 0);
        check("pin sb wdata", cap_wdata, 32'hABAB_ABAB);
        check("pin sb be", 32'(cap_be), 32'h2);
        run_op(mk(OPL, 3'd2), 32'h2, 32'h0, 32'h0, 0, 0, 0);
        check("pin lw mis", 32'(cap_mis), 32'd1);
        check("pin lw mis data", cap_data, 32'd0);
        run_op(mk(OPL, 3'd2), 32'h40, 32'h0, 32'h1111_1111, 0, T, 0);
        check("pin wait timeout err", 32'(cap_err), 32'd1);
        check("pin wait timeout data", cap_data, 32'd0);
        run_op(mk(OPL, 3'd1), 32'h46, 32'h0, 32'h8765_4321, 1, T - 1, 0);
        check("pin last-cycle rvalid err", 32'(cap_err), 32'd0);
        check("pin last-cycle rvalid data", cap_data, 32'hFFFF_8765);
        run_op(mk(OPS, 3'd2), 32'h80, 32'hCAFE_F00D, 32'h0, T, 0, 0);
        check("pin req timeout err", 32'(cap_err), 32'd1);
        run_op(mk(OPS, 3'd1), 32'h82, 32'h1234_BEEF, 32'h0, T - 1, 0, 0);
        check("pin sh wdata", cap_wdata, 32'hBEEF_BEEF);
        check("pin sh be", 32'(cap_be), 32'hC);
        run_op(mk(OPL, 3'd3), 32'h0, 32'h0, 32'h0, 0, 0, 0);
        run_op(mk(OPS, 3'd4), 32'h0, 32'h55, 32'h0, 0, 0, 0);
        run_op(mk(OPL, 3'd4), 32'h5, 32'h0, 32'h0000_F200, 0, 1, 0);
        check("pin lbu data", cap_data, 32'h0000_00F2);
        run_op(mk(OPL, 3'd1), 32'h0, 32'h0, 32'h0000_8000, 0, 0, 3);
        check("pin lh backpressure data", cap_data, 32'hFFFF_8000);
        run_op(mk(OPA, 3'd0), 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0, 2);
        run_op(mk(OPL, 3'd1), 32'h3, 32'h0, 32'h0, 0, 0, 0);

        // reset in the middle of a request, then a late rvalid
        chk_en       = 0;
        valid_i      = 1'b1;
        instr_i      = mk(OPL, 3'd2);
        result_i     = 32'h100;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        check("pre-reset mem_req_o", 32'(mem_req_o), 32'd1);
        #2 rstn_i = 1'b0;
        #1;
        check("async reset mem_req_o", 32'(mem_req_o), 32'd0);
        check("async reset ready_o", 32'(ready_o), 32'd1);
        @(posedge clk); #1;
        rstn_i       = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1357_9BDF;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        check("late rvalid valid_o", 32'(valid_o), 32'd0);
        check("late rvalid ready_o", 32'(ready_o), 32'd1);
        chk_en = 1;
        run_op(mk(OPL, 3'd2), 32'h104, 32'h0, 32'h5A5A_A5A5, 0, 0, 0);
        check("pin lw after reset", cap_data, 32'h5A5A_A5A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
